// File: rtl/mem_multiport.sv
// rtl/mem_multiport.sv - Multi-read-port synchronous memory with write bypass and zero-fill engine
module mem_multiport #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int NUM_RD     = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_en,
  input  logic [ADDR_WIDTH-1:0]        write_addr,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
  output logic [NUM_RD-1:0]            read_valid,
  output logic                         addr_err,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

  state_t                         r_state;
  logic [ADDR_WIDTH-1:0]          r_clr_cnt;
  logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
  logic [NUM_RD*DATA_WIDTH-1:0]   r_read_data;
  logic [NUM_RD-1:0]              r_read_valid;
  logic                           r_addr_err;
  logic                           r_clr_busy;
  logic                           r_clr_done;

  logic                           w_idle;
  logic                           w_wr_in_range;
  logic                           w_wr_accept;
  logic                           w_clr_write;
  logic                           w_any_err;
  logic [NUM_RD-1:0]              w_rd_accept;
  logic [NUM_RD-1:0]              w_rd_in_range;
  logic [DATA_WIDTH-1:0]          w_rd_word [NUM_RD];

  assign w_idle        = (r_state == S_IDLE);
  assign w_wr_in_range = ({1'b0, write_addr} < DEPTH_W);
  assign w_wr_accept   = rst_n && w_idle && write_en && w_wr_in_range;
  assign w_clr_write   = (r_state == S_CLEAR);

  // Per-port next read word; out-of-range ports return zero, bypass only on an accepted write.
  always_comb begin
    w_any_err     = w_idle && write_en && !w_wr_in_range;
    w_rd_accept   = '0;
    w_rd_in_range = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_word[i]     = '0;
      w_rd_in_range[i] = ({1'b0, read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_W);
      w_rd_accept[i]   = w_idle && rd_en[i];
      if (w_rd_accept[i] && !w_rd_in_range[i]) begin
        w_any_err = 1'b1;
      end
      if (w_rd_in_range[i]) begin
        if (BYPASS && w_wr_accept && (write_addr == read_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
          w_rd_word[i] = write_data;
        end else begin
          w_rd_word[i] = r_mem[read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  // Storage is deliberately left unreset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (w_clr_write) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_accept) begin
      r_mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_read_data  <= '0;
      r_read_valid <= '0;
      r_addr_err   <= 1'b0;
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
    end else begin
      r_addr_err   <= w_any_err;
      r_read_valid <= w_rd_accept;
      for (int i = 0; i < NUM_RD; i++) begin
        if (w_rd_accept[i]) begin
          r_read_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word[i];
        end
      end
      case (r_state)
        S_IDLE: begin
          r_clr_done <= 1'b0;
          if (clr_start) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == LAST_ADDR) begin
            r_state    <= S_DONE;
            r_clr_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_clr_done <= 1'b0;
          r_clr_busy <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_clr_done <= 1'b0;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign addr_err   = r_addr_err;
  assign clr_busy   = r_clr_busy;
  assign clr_done   = r_clr_done;

endmodule

// File: tb/tb_mem_multiport.sv
// tb/tb_mem_multiport.sv - Bench for mem_multiport: instance 0 is DEPTH=16/BYPASS=1, instance 1 is DEPTH=12/BYPASS=0
module tb_mem_multiport;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            write_en = 1'b0;
  logic [AW-1:0]   write_addr = '0;
  logic [DW-1:0]   write_data = '0;
  logic [NR-1:0]   rd_en = '0;
  logic [NR*AW-1:0] read_addr = '0;
  logic            clr_start = 1'b0;

  logic [NR*DW-1:0] rd0, rd1;
  logic [NR-1:0]    rv0, rv1;
  logic             ae0, ae1, cb0, cb1, cd0, cd1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .NUM_RD(NR), .BYPASS(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .rd_en(rd_en), .read_addr(read_addr), .read_data(rd0), .read_valid(rv0), .addr_err(ae0),
    .clr_start(clr_start), .clr_busy(cb0), .clr_done(cd0));

  mem_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12), .NUM_RD(NR), .BYPASS(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .rd_en(rd_en), .read_addr(read_addr), .read_data(rd1), .read_valid(rv1), .addr_err(ae1),
    .clr_start(clr_start), .clr_busy(cb1), .clr_done(cd1));

  // Reference model: word array per instance plus remaining clear-cycle count.
  logic [DW-1:0] m_mem   [2][16];
  bit            m_known [2][16];
  int            m_left  [2];
  logic [DW-1:0] e_data  [2][NR];
  bit            e_dknown[2][NR];
  logic [NR-1:0] e_valid [2];
  bit            e_err   [2];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k]  = 0;
      e_valid[k] = '0;
      e_err[k]   = 1'b0;
      for (int p = 0; p < NR; p++) begin
        e_data[k][p]   = '0;
        e_dknown[k][p] = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int d;
      bit wok;
      bit err;
      int a;
      int idx;
      d = dep(k);
      if (m_left[k] > 0) begin
        idx = d + 1 - m_left[k];
        if (idx < d) begin
          m_mem[k][idx]   = '0;
          m_known[k][idx] = 1'b1;
        end
        m_left[k]  = m_left[k] - 1;
        e_valid[k] = '0;
        e_err[k]   = 1'b0;
      end else begin
        wok = write_en && (int'(write_addr) < d);
        err = write_en && !wok;
        for (int p = 0; p < NR; p++) begin
          if (rd_en[p]) begin
            a = int'(read_addr[p*AW +: AW]);
            e_valid[k][p] = 1'b1;
            if (a >= d) begin
              e_data[k][p]   = '0;
              e_dknown[k][p] = 1'b1;
              err = 1'b1;
            end else if (k == 0 && wok && a == int'(write_addr)) begin
              e_data[k][p]   = write_data;
              e_dknown[k][p] = 1'b1;
            end else begin
              e_data[k][p]   = m_mem[k][a];
              e_dknown[k][p] = m_known[k][a];
            end
          end else begin
            e_valid[k][p] = 1'b0;
          end
        end
        if (wok) begin
          m_mem[k][write_addr]   = write_data;
          m_known[k][write_addr] = 1'b1;
        end
        e_err[k] = err;
        if (clr_start) m_left[k] = d + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [NR*DW-1:0] rd;
        rd = (k == 0) ? rd0 : rd1;
        chk("clr_busy",   k, 32'((k == 0) ? cb0 : cb1), 32'(m_left[k] > 0));
        chk("clr_done",   k, 32'((k == 0) ? cd0 : cd1), 32'(m_left[k] == 1));
        chk("addr_err",   k, 32'((k == 0) ? ae0 : ae1), 32'(e_err[k]));
        chk("read_valid", k, 32'((k == 0) ? rv0 : rv1), 32'(e_valid[k]));
        for (int p = 0; p < NR; p++) begin
          if (e_dknown[k][p]) chk("read_data", k, 32'(rd[p*DW +: DW]), 32'(e_data[k][p]));
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [NR-1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic cs);
    @(negedge clk);
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    rd_en      = re;
    read_addr  = {a1, a0};
    clr_start  = cs;
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      idle(1);
      #1;
      ok = !cb0 && !cb1;
    end
    chk("wait_idle", 0, 32'(ok), 32'd1);
  endtask

  int nb0, nb1, nd0, nd1;
  logic [AW-1:0] r_wa, r_a0, r_a1;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) begin
        m_mem[k][a]   = '0;
        m_known[k][a] = 1'b0;
      end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_read_data", 0, rd0, 32'h0);
    chk("reset_read_data", 1, rd1, 32'h0);
    chk("reset_valid_busy", 0, {ae0, cb0, cd0, rv0}, 32'h0);
    chk("reset_valid_busy", 1, {ae1, cb1, cd1, rv1}, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    cyc(1'b0, '0, '0, '0, '0, '0, 1'b1);
    #1;
    nb0 = int'(cb0); nb1 = int'(cb1); nd0 = int'(cd0); nd1 = int'(cd1);
    for (int i = 0; i < 24; i++) begin
      idle(1);
      #1;
      nb0 += int'(cb0); nb1 += int'(cb1); nd0 += int'(cd0); nd1 += int'(cd1);
    end
    chk("busy_cycles", 0, 32'(nb0), 32'd17);
    chk("busy_cycles", 1, 32'(nb1), 32'd13);
    chk("done_pulses", 0, 32'(nd0), 32'd1);
    chk("done_pulses", 1, 32'(nd1), 32'd1);

    for (int a = 0; a < 16; a++) begin
      cyc(1'b0, '0, '0, 2'b11, AW'(a), AW'(a), 1'b0);
      if (a == 7) begin
        #1;
        chk("cleared_read", 0, {rv0, rd0[23:0]}, {2'b11, 24'h0});
      end
    end

    cyc(1'b1, 4'd5, 16'hBEEF, 2'b00, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 2'b11, 4'd5, 4'd4, 1'b0);
    #1;
    chk("beef_read", 0, rd0, 32'h0000_BEEF);

    cyc(1'b1, 4'd3, 16'hAAAA, 2'b00, '0, '0, 1'b0);
    cyc(1'b1, 4'd3, 16'h1234, 2'b11, 4'd3, 4'd3, 1'b0);
    #1;
    chk("collide_bypass", 0, rd0, 32'h1234_1234);
    chk("collide_nobypass", 1, rd1, 32'hAAAA_AAAA);

    cyc(1'b1, 4'd2, 16'h5555, 2'b00, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 2'b11, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      #1;
      chk("hold_data", 0, rd0, 32'h5555_5555);
      chk("hold_valid", 0, 32'(rv0), 32'h0);
    end

    cyc(1'b1, 4'd14, 16'hDEAD, 2'b00, '0, '0, 1'b0);
    #1;
    chk("oor_write_err", 1, 32'(ae1), 32'd1);
    chk("inrange_write_err", 0, 32'(ae0), 32'd0);
    cyc(1'b0, '0, '0, 2'b01, 4'd13, 4'd0, 1'b0);
    #1;
    chk("oor_read", 1, {ae1, rv1, rd1[15:0]}, {1'b1, 2'b01, 16'h0});

    for (int n = 0; n < 400; n++) begin
      r_wa = AW'($urandom_range(0, 15));
      r_a0 = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, 15));
      r_a1 = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), r_wa, 16'($urandom), 2'($urandom_range(0, 3)),
          r_a0, r_a1, ($urandom_range(0, 59) == 0));
    end
    wait_idle();

    for (int a = 0; a < 16; a++) cyc(1'b1, AW'(a), 16'hC000 + 16'(a), 2'b00, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, '0, 1'b1);
    idle(6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_busy", 0, {cb0, cb1, cd0, cd1}, 32'h0);
    chk("async_reset_read", 0, {rv0, rv1}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd0 = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      #1;
      nd0 += int'(cd0) + int'(cd1) + int'(cb0) + int'(cb1);
    end
    chk("no_done_after_reset", 0, 32'(nd0), 32'd0);
    cyc(1'b0, '0, '0, 2'b11, 4'd5, 4'd6, 1'b0);
    #1;
    chk("partial_clear", 0, rd0, 32'hC006_0000);
    chk("partial_clear", 1, rd1, 32'hC006_0000);
    for (int a = 0; a < 16; a += 2) cyc(1'b0, '0, '0, 2'b11, AW'(a), AW'(a + 1), 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_multiport.md
# mem_multiport

Parametrised synchronous memory for the autoencoder datapath, used as the next-generation weight/activation store. It has one write port, NUM_RD independent registered read ports, and optional write-to-read bypass. A built-in clear engine zero-fills the array between inference runs. All logic runs on the rising edge of a single clock, with a deterministic one-cycle read latency and per-port valid flags.

## Interface
- ADDR_WIDTH, 4, address width of every port
- DATA_WIDTH, 16, word width
- DEPTH, 16, number of words; must satisfy DEPTH <= 2^ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..8)
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns old contents
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_en  in  1  write request
- write_addr  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- rd_en  in  NUM_RD  per-port read request; bit i controls port i
- read_addr  in  NUM_RD*ADDR_WIDTH  flattened addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  NUM_RD*DATA_WIDTH  flattened registered read data, same packing
- read_valid  out  NUM_RD  per-port valid, one cycle after an accepted read
- addr_err  out  1  one-cycle pulse: any accepted access in the previous cycle was out of range
- clr_start  in  1  request to zero-fill the whole array
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- Reset (rst_n low, asynchronous) drives outputs as follows:
  - read_data = 0, read_valid = 0, addr_err = 0
  - clr_busy = 0, clr_done = 0, FSM = IDLE, clear counter = 0
- Array contents are not reset. Software issues clr_start to clear them.
- Write: on a rising edge with write_en=1, FSM=IDLE and write_addr < DEPTH, the array stores write_data at write_addr.
  - If write_addr >= DEPTH, the write is dropped and addr_err pulses.
- Read port i: on a rising edge with rd_en[i]=1 and FSM=IDLE:
  - read_data[i] loads array[read_addr[i]] and read_valid[i]=1.
  - If read_addr[i] >= DEPTH: read_data[i]=0, read_valid[i]=1, addr_err pulses.
  - If rd_en[i]=0, read_data[i] holds its value and read_valid[i]=0.
- Read/write collision, same address, same edge:
  - BYPASS=1: read returns write_data.
  - BYPASS=0: read returns the previous contents.
  - Any number of ports may hit the same address; all receive identical data.
- Clear FSM:
  - IDLE: clr_start=1 -> CLEAR, counter=0, clr_busy=1.
  - CLEAR: each cycle writes array[counter]=0 and increments counter. Once the cycle writing DEPTH-1 completes -> DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
- While in CLEAR or DONE:
  - External writes are ignored, without addr_err.
  - rd_en is ignored: read_valid=0 and read_data holds.
  - clr_start is ignored.
- clr_start and write_en asserted on the same edge in IDLE: the write is performed first, then the clear begins next cycle (the word is subsequently zeroed).
- Reset asserted mid-clear: FSM returns to IDLE immediately, leaving the array partially cleared. No clr_done is issued.

## Timing
- Read latency 1 cycle: address sampled on edge N, read_data/read_valid valid after edge N and until edge N+1.
- Write-then-read on consecutive edges returns the new data regardless of BYPASS.
- Clear duration: clr_busy is high for exactly DEPTH+1 cycles (DEPTH CLEAR cycles plus 1 DONE cycle). clr_done is high in the last of these.
- First accepted access is on the edge after clr_done.
- addr_err asserts one cycle after the offending edge and lasts 1 cycle.
- No combinational path from any input to any output.

## Test plan
- Reset, then clr_start: clr_busy high for 17 cycles and clr_done pulses once. Reading all 16 addresses on both ports then returns 0 with read_valid=1 one cycle later.
- Write 0xBEEF to addr 5, then read addr 5 on port 0 and addr 4 on port 1 the next cycle: read_data port 0 = 0xBEEF, port 1 = 0x0000.
- Same edge: write 0x1234 to addr 3 while both ports read addr 3 (old value 0xAAAA). BYPASS=1 gives both ports 0x1234; BYPASS=0 gives 0xAAAA.
- Hold test: read addr 2 (=0x5555), then drop rd_en for 3 cycles. read_data stays 0x5555 and read_valid=0 during the hold.
- With DEPTH=12, ADDR_WIDTH=4: write to addr 14 leaves the array unchanged and pulses addr_err; a read of addr 13 returns 0, read_valid=1, and pulses addr_err.
- Assert rst_n low at CLEAR cycle 6. Outputs go to reset values asynchronously. Words 0..5 read 0 afterwards, words 6..15 keep their prior data, and no clr_done occurs.
